window_fetch_unit: RTL and testbench
====================================

Name: window_fetch_unit

Overview:
Parametrised successor of the fixed 3x3 / 128x128 / 8-bit window storing register. Given a centre pixel (row, col), it fetches a KxK neighbourhood from a synchronous image SRAM (1-cycle read latency), one address per cycle. Out-of-image positions are zero-padded without a memory access. It presents the whole window plus an overflow-free sum to the downstream filter/convolution stage.

Parameters:
DATA_W, 8, pixel width in bits
ROW_W, 7, row address bits
COL_W, 7, column address bits
IMG_H, 128, image height in pixels (<= 2**ROW_W)
IMG_W, 128, image width in pixels (<= 2**COL_W)
K, 3, window side; odd, 3..7; PAD = (K-1)/2
SUM_W, DATA_W+$clog2(K*K), sum width (derived localparam, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
ctr_row  in  ROW_W  centre row (image coordinates)
ctr_col  in  COL_W  centre column
mem_en  out  1  SRAM read enable
mem_addr  out  ROW_W+COL_W  {row, col} read address
mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_en
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; window and sum valid
win_valid  out  1  high from done until the next accepted start
win_out  out  K*K*DATA_W  window, element i=r*K+c at bits [i*DATA_W +: DATA_W], r/c from top-left
sum  out  SUM_W  unsigned sum of all K*K elements of win_out

Behaviour:
- Reset: state IDLE; mem_en=0, mem_addr=0, busy=0, done=0, win_valid=0, win_out=0, sum=0. Reset mid-fetch aborts; no done is issued.
- States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1, latch ctr_row/ctr_col, clear the fetch index, clear win_valid, go to FETCH. When start=0, hold outputs.
- FETCH: lasts K*K cycles, with index n = 0..K*K-1 in row-major order.
  - Target position: tr = ctr_row - PAD + n/K, tc = ctr_col - PAD + n%K. Computed signed, at least 1 bit wider than ROW_W/COL_W.
  - In range (0 <= tr < IMG_H and 0 <= tc < IMG_W): mem_en=1, mem_addr={tr,tc}. The element is written from mem_rdata in the next cycle.
  - Out of range: mem_en=0, mem_addr=0. The element is written as 0 in the next cycle; mem_rdata is ignored.
  - A one-entry pipeline (pending valid, pad flag, index) carries each request to its capture cycle.
- DRAIN: one cycle; captures the last element; mem_en=0.
- DONE: one cycle. done=1, win_valid rises, sum is registered in this cycle. Next state is IDLE.
- Latency: start sampled at edge 0 -> done high in cycle K*K+2 (11 for K=3).
- busy=1 in FETCH, DRAIN and DONE.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored; it is accepted in the following IDLE cycle.
- win_out/sum hold their values while IDLE until the next accepted start. Elements update in place during a fetch, so they are only meaningful when win_valid=1.
- sum: full SUM_W precision, never truncated. K=3, DATA_W=8 gives SUM_W=12, max 2295.
- The centre pixel itself is not range-checked; every target position is individually checked, so any centre value is legal.

Optional Feature:
SLIDE_REUSE_EN
- Defined: a start is a slide when all of these hold: win_valid=1, ctr_row equals the previous ctr_row, and ctr_col equals the previous ctr_col + 1 (no wrap; previous col = 2**COL_W-1 is never a slide).
- On a slide:
  - Shift the window left by one column: columns 1..K-1 move to 0..K-2.
  - Fetch only the K new right-column positions (n = c*K+K-1, rows top-to-bottom), with the same padding rules.
  - FETCH lasts K cycles; done arrives in cycle K+2 (5 for K=3).
- Any non-slide start does a full fetch.
- Not defined: every start does a full K*K fetch; no previous-centre registers exist.

Test Plan:
- Interior fetch: IMG 128x128, pixel(r,c)=(r+c)&8'hFF, start ctr=(10,20) -> 9 reads 9..11 x 19..21, done in cycle 11, win_out[0]=28, element 4=30, sum=270.
- Corner padding: ctr=(0,0) -> mem_en high only for 4 positions; elements 0,1,2,3,6 = 0; sum = pix(0,0)+pix(0,1)+pix(1,0)+pix(1,1).
- Far corner: ctr=(127,127) -> no address beyond 127 issued; 5 zero elements; all-255 image gives sum=1020.
- Overflow: all pixels 255, ctr=(64,64) -> sum=2295 (12'h8F7), no truncation.
- Busy/reset: start pulsed during FETCH -> ignored, single done. rst at FETCH cycle 4 -> all outputs 0 next cycle, no done; a fresh start then completes normally.
- SLIDE_REUSE_EN: ctr (10,20) then (10,21) -> second done at cycle 5 with only 3 mem_en cycles, win_out identical to a full fetch. (10,21) then (11,21) -> full 9-read fetch.

Source files
------------

// File: rtl/window_fetch_unit.sv
// window_fetch_unit: fetches a KxK zero-padded neighbourhood from a 1-cycle SRAM and presents window + sum.
// Optional SLIDE_REUSE_EN: a start one column right of the last centre reuses K-1 columns and fetches only K pixels.
module window_fetch_unit #(
  parameter int DATA_W = 8,
  parameter int ROW_W = 7,
  parameter int COL_W = 7,
  parameter int IMG_H = 128,
  parameter int IMG_W = 128,
  parameter int K = 3,
  localparam int SUM_W = DATA_W + $clog2(K*K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ROW_W-1:0]         ctr_row,
  input  logic [COL_W-1:0]         ctr_col,
  output logic                     mem_en,
  output logic [ROW_W+COL_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     win_valid,
  output logic [K*K*DATA_W-1:0]    win_out,
  output logic [SUM_W-1:0]         sum
);
  localparam int PAD = (K-1)/2;
  localparam int KW = $clog2(K);
  localparam int IW = $clog2(K*K);
  localparam int RW = ROW_W + 2;
  localparam int CW = COL_W + 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [KW-1:0] r_q, r_d, c_q, c_d;
  logic [IW-1:0] idx_q, idx_d;
  logic slide_q, slide_d, pend_q, pend_d, pad_q, pad_d, win_valid_q, win_valid_d;
  logic [K*K*DATA_W-1:0] win_q, win_d;
  logic [SUM_W-1:0] sum_q, sum_d, tot;
  logic [RW-1:0] tr;
  logic [CW-1:0] tc;
  logic in_rng, last, slide;
`ifdef SLIDE_REUSE_EN
  assign slide = win_valid_q && ctr_row == row_q && col_q != '1 && ctr_col == col_q + COL_W'(1);
`else
  assign slide = 1'b0;
`endif
  // Target position in two's complement one bit wider than needed, so negatives show up in the MSB
  assign tr = RW'(row_q) + RW'(r_q) - RW'(PAD);
  assign tc = CW'(col_q) + CW'(c_q) - CW'(PAD);
  assign in_rng = !tr[RW-1] && tr < RW'(IMG_H) && !tc[CW-1] && tc < CW'(IMG_W);
  assign last = r_q == KW'(K-1) && c_q == KW'(K-1);
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    r_d = r_q;
    c_d = c_q;
    idx_d = idx_q;
    slide_d = slide_q;
    win_valid_d = win_valid_q;
    pend_d = 1'b0;
    pad_d = 1'b0;
    mem_en = 1'b0;
    mem_addr = '0;
    win_d = win_q;
    if (pend_q) win_d[idx_q*DATA_W +: DATA_W] = pad_q ? '0 : mem_rdata;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        row_d = ctr_row;
        col_d = ctr_col;
        slide_d = slide;
        r_d = '0;
        c_d = slide ? KW'(K-1) : '0;
        win_valid_d = 1'b0;
        if (slide)
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K-1; c++)
              win_d[(r*K+c)*DATA_W +: DATA_W] = win_q[(r*K+c+1)*DATA_W +: DATA_W];
      end
      FETCH: begin
        mem_en = in_rng;
        mem_addr = in_rng ? {tr[ROW_W-1:0], tc[COL_W-1:0]} : '0;
        pend_d = 1'b1;
        pad_d = !in_rng;
        idx_d = IW'(r_q) * IW'(K) + IW'(c_q);
        state_d = last ? DRAIN : FETCH;
        if (!last) begin
          r_d = (slide_q || c_q == KW'(K-1)) ? r_q + 1'b1 : r_q;
          c_d = slide_q ? c_q : (c_q == KW'(K-1) ? '0 : c_q + 1'b1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        win_valid_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tot = '0;
    for (int i = 0; i < K*K; i++) tot = tot + SUM_W'(win_d[i*DATA_W +: DATA_W]);
    sum_d = state_q == DRAIN ? tot : sum_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      r_q <= '0;
      c_q <= '0;
      idx_q <= '0;
      slide_q <= 1'b0;
      pend_q <= 1'b0;
      pad_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      r_q <= r_d;
      c_q <= c_d;
      idx_q <= idx_d;
      slide_q <= slide_d;
      pend_q <= pend_d;
      pad_q <= pad_d;
      win_valid_q <= win_valid_d;
      win_q <= win_d;
      sum_q <= sum_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign win_valid = win_valid_q;
  assign win_out = win_q;
  assign sum = sum_q;
endmodule

// File: tb/tb_window_fetch_unit.sv
// tb_window_fetch_unit: directed + random fetches of window_fetch_unit against a pixel-level reference model.
module tb_window_fetch_unit;
  localparam int K = 3;
  localparam int PAD = 1;
  localparam int IMG = 128;
  logic clk = 1'b0;
  logic rst, start;
  logic [6:0] ctr_row, ctr_col;
  logic mem_en;
  logic [13:0] mem_addr;
  logic [7:0] mem_rdata = '0;
  logic busy, done, win_valid;
  logic [71:0] win_out;
  logic [11:0] sum;
  logic [7:0] img [0:16383];
  int errors = 0;
  int checks = 0;
  int exp_win [K*K];
  int exp_addr [$];
  int obs_addr [$];
  bit pv_valid = 0;
  int pv_row = 0;
  int pv_col = 0;

  window_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .ctr_row(ctr_row), .ctr_col(ctr_col),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .win_valid(win_valid), .win_out(win_out), .sum(sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_rdata <= img[mem_addr];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        img[r*IMG+c] = mode == 0 ? 8'((r + c) & 255) : mode == 1 ? 8'd255 : 8'($urandom_range(0, 255));
  endtask

  task automatic run(input int row, input int col, input int poke);
    bit sl;
    int cyc, dn, tr, tc, es;
    logic [71:0] ew;
    sl = 0;
`ifdef SLIDE_REUSE_EN
    sl = pv_valid && row == pv_row && col == pv_col + 1;
`endif
    exp_addr.delete();
    if (sl)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++) exp_win[r*K+c] = exp_win[r*K+c+1];
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        if (sl && c != K-1) continue;
        tr = row - PAD + r;
        tc = col - PAD + c;
        if (tr >= 0 && tr < IMG && tc >= 0 && tc < IMG) begin
          exp_win[r*K+c] = int'(img[tr*IMG+tc]);
          exp_addr.push_back(tr*IMG+tc);
        end else exp_win[r*K+c] = 0;
      end
    ew = '0;
    es = 0;
    for (int i = 0; i < K*K; i++) begin
      ew[i*8 +: 8] = 8'(exp_win[i]);
      es += exp_win[i];
    end
    start = 1'b1;
    ctr_row = 7'(row);
    ctr_col = 7'(col);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    chk("busy_cycle1", busy, 1);
    chk("valid_cleared", win_valid, 0);
    obs_addr.delete();
    while (!done && cyc < 40) begin
      if (mem_en) obs_addr.push_back(int'(mem_addr));
      @(posedge clk);
      #1;
      cyc++;
      start = cyc == poke;
      if (start) begin
        ctr_row = 7'(row + 5);
        ctr_col = 7'(col + 3);
      end
    end
    start = 1'b0;
    chk("latency", 72'(cyc), sl ? 72'(K+2) : 72'(K*K+2));
    chk("read_count", 72'(obs_addr.size()), 72'(exp_addr.size()));
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      chk("read_addr", 72'(obs_addr[i]), 72'(exp_addr[i]));
    chk("win_out", win_out, ew);
    chk("sum", 72'(sum), 72'(es));
    chk("valid_at_done", win_valid, 1);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("win_hold", win_out, ew);
    if (poke != 0) begin
      dn = 0;
      for (int i = 0; i < 14; i++) begin
        @(posedge clk);
        #1;
        dn += int'(done);
      end
      chk("poke_ignored", 72'(dn), 0);
    end
    pv_valid = 1;
    pv_row = row;
    pv_col = col;
  endtask

  initial begin
    int row, col, dn;
    rst = 1'b1;
    start = 1'b0;
    ctr_row = '0;
    ctr_col = '0;
    fill(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", win_valid, 0);
    chk("rst_win", win_out, 0);
    chk("rst_sum", sum, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(10, 20, 0);
    chk("interior_e0", win_out[7:0], 28);
    chk("interior_e4", win_out[39:32], 30);
    chk("interior_sum", sum, 270);
    run(10, 21, 0);
    run(11, 21, 0);
    run(0, 0, 0);
    chk("corner_reads", 72'(obs_addr.size()), 4);
    fill(1);
    run(64, 64, 0);
    chk("overflow_sum", sum, 12'h8F7);
    run(127, 127, 0);
    chk("far_corner_sum", sum, 1020);
    chk("far_corner_reads", 72'(obs_addr.size()), 4);
    fill(2);
    for (int it = 0; it < 24; it++) begin
      if (it % 8 == 7) fill(2);
      if ($urandom_range(0, 1) == 1 && pv_col < IMG-1) begin
        row = pv_row;
        col = pv_col + 1;
      end else begin
        row = $urandom_range(0, IMG-1);
        col = $urandom_range(0, IMG-1);
      end
      run(row, col, 0);
    end
    run(30, 40, 3);
    start = 1'b1;
    ctr_row = 7'd50;
    ctr_col = 7'd50;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_mem_en", mem_en, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", win_valid, 0);
    chk("abort_win", win_out, 0);
    chk("abort_sum", sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pv_valid = 0;
    foreach (exp_win[i]) exp_win[i] = 0;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("abort_no_done", 72'(dn), 0);
    run(50, 50, 0);
    run(50, 51, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
